time_entry_loader: RTL

TIME_ENTRY_LOADER -- requirements
Module: time_entry_loader

---
 rtl/time_entry_loader_pkg.sv | 29 ++
 rtl/time_entry_loader_if.sv | 31 +++
 rtl/time_entry_loader_bcd_digit_shift.sv | 51 +++++
 rtl/time_entry_loader.sv | 134 +++++++++++++
 4 files changed

// File: rtl/time_entry_loader_pkg.sv
// Shared definitions for the microwave time-entry loader.
//   - FSM state encodings (2-bit, legacy-compatible localparams)
//   - digit-count limit and BCD maximum digit values
//   - small helpers for classifying keypad digits
package time_entry_loader_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENTRY = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    // Maximum number of digits the operator may enter.
    localparam logic [1:0] DIGIT_LIMIT   = 2'd3;
    // Largest legal BCD value for a units (mod-10) digit.
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    // Largest legal value for the seconds-tens (mod-6) digit.
    localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

    // True when the keypad code is a decimal digit 0..9.
    function automatic logic is_bcd_digit(input logic [3:0] d);
        return (d <= BCD_MAX_DIGIT);
    endfunction

    // True when the value cannot legally be a seconds-tens digit.
    function automatic logic exceeds_tens(input logic [3:0] d);
        return (d > BCD_MAX_TENS);
    endfunction

endpackage

// File: rtl/time_entry_loader_if.sv
// Keypad / counter-side bundle of the time-entry loader.
//   master : the environment (keypad encoder, controls, counters) - drives
//            key_digit, key_valid, start, cancel, timer_done
//   slave  : the loader - drives counter load data, loadn, run_en,
//            digit_cnt and entry_err
interface time_entry_loader_if;
    logic [3:0] key_digit;
    logic       key_valid;
    logic       start;
    logic       cancel;
    logic       timer_done;
    logic [3:0] sec_ones_data;
    logic [2:0] sec_tens_data;
    logic [3:0] min_data;
    logic       loadn;
    logic       run_en;
    logic [1:0] digit_cnt;
    logic       entry_err;

    modport master (
        output key_digit, key_valid, start, cancel, timer_done,
        input  sec_ones_data, sec_tens_data, min_data, loadn, run_en,
               digit_cnt, entry_err
    );

    modport slave (
        input  key_digit, key_valid, start, cancel, timer_done,
        output sec_ones_data, sec_tens_data, min_data, loadn, run_en,
               digit_cnt, entry_err
    );
endinterface

// File: rtl/time_entry_loader_bcd_digit_shift.sv
// bcd_digit_shift: three-stage digit shifter holding the entered time.
// Each shift pushes a new digit in at the seconds-units end:
//   hi <= tens, tens <= ones[2:0], ones <= din.
// Ports:
//   clk   - clock, rising edge
//   clear - synchronous active-high reset
//   shift - load din and shift the older digits up
//   flush - synchronous clear of all three stages
//   din   - new BCD digit
//   ones  - seconds-units digit (4 bits)
//   tens  - seconds-tens digit (3 bits, mod-6 counter width)
//   hi    - minutes digit (4 bits)
module bcd_digit_shift (
    input  logic       clk,
    input  logic       clear,
    input  logic       shift,
    input  logic       flush,
    input  logic [3:0] din,
    output logic [3:0] ones,
    output logic [2:0] tens,
    output logic [3:0] hi
);

    logic [3:0] ones_q;
    logic [2:0] tens_q;
    logic [3:0] hi_q;

    // Digit registers: reset/flush to zero, otherwise shift on request.
    always_ff @(posedge clk) begin
        if (clear || flush) begin
            ones_q <= 4'd0;
            tens_q <= 3'd0;
            hi_q   <= 4'd0;
        end else if (shift) begin
            // The tens stage is only 3 bits wide; an out-of-range units
            // digit is truncated here and flagged by the controller.
            hi_q   <= {1'b0, tens_q};
            tens_q <= ones_q[2:0];
            ones_q <= din;
        end else begin
            ones_q <= ones_q;
            tens_q <= tens_q;
            hi_q   <= hi_q;
        end
    end

    assign ones = ones_q;
    assign tens = tens_q;
    assign hi   = hi_q;

endmodule

// File: rtl/time_entry_loader.sv
// time_entry_loader: collects up to three keypad digits (M:SS) and
// transfers them into cascaded down-counters with a one-cycle active-low
// load strobe, then enables counting until terminal count or cancel.
// Ports:
//   clk   - clock, rising edge
//   clear - synchronous active-high reset
//   bus   - slave side of time_entry_loader_if (keypad, controls,
//           counter load data, loadn, run_en, digit_cnt, entry_err)
module time_entry_loader
    import time_entry_loader_pkg::*;
(
    input  logic                       clk,
    input  logic                       clear,
    time_entry_loader_if.slave         bus
);

    logic [1:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       bad_q, bad_d;
    logic       err_q, err_d;
    logic       loadn_q;
    logic       run_en_q;

    logic       shift_s;
    logic       flush_s;
    logic [3:0] ones_s;
    logic [2:0] tens_s;
    logic [3:0] hi_s;
    logic       any_nz_s;

    bcd_digit_shift u_shift (
        .clk   (clk),
        .clear (clear),
        .shift (shift_s),
        .flush (flush_s),
        .din   (bus.key_digit),
        .ones  (ones_s),
        .tens  (tens_s),
        .hi    (hi_s)
    );

    assign any_nz_s = (|ones_s) | (|tens_s) | (|hi_s);

    // Next-state logic; priority cancel > timer_done > start > key_valid.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        err_d   = 1'b0;
        shift_s = 1'b0;
        flush_s = 1'b0;
        if (bus.cancel) begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
            bad_d   = 1'b0;
            flush_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_ENTRY: begin
                    if ((state_q == ST_ENTRY) && bus.start) begin
                        // Any key arriving with start is dropped here.
                        if (!bad_q && any_nz_s) begin
                            state_d = ST_LOAD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (bus.key_valid && !is_bcd_digit(bus.key_digit)) begin
                        err_d = 1'b1;
                    end else if (bus.key_valid && (cnt_q < DIGIT_LIMIT)) begin
                        shift_s = 1'b1;
                        cnt_d   = cnt_q + 2'd1;
                        state_d = ST_ENTRY;
                        // The current units digit is about to become tens.
                        if (exceeds_tens(ones_s)) begin
                            bad_d = 1'b1;
                        end else begin
                            bad_d = bad_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_LOAD: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (bus.timer_done) begin
                        state_d = ST_IDLE;
                        cnt_d   = 2'd0;
                        bad_d   = 1'b0;
                        flush_s = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                    bad_d   = 1'b0;
                    flush_s = 1'b1;
                end
            endcase
        end
    end

    // State and registered outputs; strobes are decoded from the next
    // state so loadn falls on the same edge that enters LOAD.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            bad_q    <= 1'b0;
            err_q    <= 1'b0;
            loadn_q  <= 1'b1;
            run_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            loadn_q  <= (state_d != ST_LOAD);
            run_en_q <= (state_d == ST_RUN);
        end
    end

    assign bus.sec_ones_data = ones_s;
    assign bus.sec_tens_data = tens_s;
    assign bus.min_data      = hi_s;
    assign bus.loadn         = loadn_q;
    assign bus.run_en        = run_en_q;
    assign bus.digit_cnt     = cnt_q;
    assign bus.entry_err     = err_q;

endmodule
